// File: rtl/text_console_writer.sv
// Console front end: codepoint stream in, cursor/attribute tracking,
// screenbuffer and colour-buffer byte-lane writes out on the system bus.
module text_console_writer #(
  parameter logic [31:0] SCREENBUFFER_BASE_ADDR = 32'h10000,
  parameter int          COLS                   = 80,
  parameter int          ROWS                   = 30,
  parameter logic [11:0] DEFAULT_COLOR          = 12'h03F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [11:0] color_in,
  input  logic        color_we,
  input  logic        clear,
  output logic        busy,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic        wen,
  output logic        ren,
  input  logic        ready
);

  localparam logic [31:0] BASE      = SCREENBUFFER_BASE_ADDR;
  localparam logic [31:0] COL_BASE  = BASE + 32'(ROWS * COLS);
  localparam logic [11:0] LCHR_LAST = 12'(COLS / 4 - 1);
  localparam logic [11:0] LCOL_LAST = 12'(COLS - 1);
  localparam logic [11:0] CCHR_LAST = 12'(ROWS * COLS / 4 - 1);
  localparam logic [11:0] CCOL_LAST = 12'(ROWS * COLS - 1);
  localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
  localparam logic [31:0] SPACES    = 32'h20202020;

  typedef enum logic [2:0] {
    IDLE,
    WR_CHAR,
    WR_COLOR,
    LINE_CHR,
    LINE_COL,
    CLR_CHR,
    CLR_COL
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [11:0] attr_q, attr_d;
  logic [11:0] lat_q, lat_d;
  logic [7:0]  char_q, char_d;
  logic [11:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        wen_q, wen_d;

  logic        issue;
  logic        done;
  logic [4:0]  nxt_row;
  logic [11:0] idx;
  logic [11:0] lbase;
  logic [11:0] lcell;

  assign done    = wen_q & ready;
  assign nxt_row = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
  assign idx     = 12'(row_q) * 12'(COLS) + {5'b0, col_q};
  assign lbase   = 12'(clr_row_d) * 12'(COLS);
  assign lcell   = lbase + cnt_d;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    clr_row_d  = clr_row_q;
    lat_d      = lat_q;
    char_d     = char_q;
    cnt_d      = cnt_q;
    attr_d     = color_we ? color_in : attr_q;
    issue      = 1'b0;
    char_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        char_ready = ~clear;
        if (clear) begin
          lat_d   = attr_q;
          cnt_d   = '0;
          state_d = CLR_CHR;
          issue   = 1'b1;
        end else if (char_valid) begin
          char_d = char_in;
          lat_d  = attr_q;
          case (char_in)
            8'h0D: col_d = '0;
            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h0A: begin
              col_d     = '0;
              row_d     = nxt_row;
              clr_row_d = nxt_row;
              cnt_d     = '0;
              state_d   = LINE_CHR;
              issue     = 1'b1;
            end
            default: begin
              state_d = WR_CHAR;
              issue   = 1'b1;
            end
          endcase
        end
      end
      WR_CHAR: begin
        if (done) begin
          state_d = WR_COLOR;
          issue   = 1'b1;
        end
      end
      WR_COLOR: begin
        if (done) begin
          if (col_q == COL_LAST) begin
            // cursor moves only once the new row is blank
            clr_row_d = nxt_row;
            cnt_d     = '0;
            state_d   = LINE_CHR;
            issue     = 1'b1;
          end else begin
            col_d   = col_q + 7'd1;
            state_d = IDLE;
          end
        end
      end
      LINE_CHR: begin
        if (done) begin
          issue = 1'b1;
          if (cnt_q == LCHR_LAST) begin
            cnt_d   = '0;
            state_d = LINE_COL;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      LINE_COL: begin
        if (done) begin
          if (cnt_q == LCOL_LAST) begin
            col_d   = '0;
            row_d   = clr_row_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 12'd1;
            issue = 1'b1;
          end
        end
      end
      CLR_CHR: begin
        if (done) begin
          issue = 1'b1;
          if (cnt_q == CCHR_LAST) begin
            cnt_d   = '0;
            state_d = CLR_COL;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      CLR_COL: begin
        if (done) begin
          if (cnt_q == CCOL_LAST) begin
            col_d   = '0;
            row_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 12'd1;
            issue = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wen_d   = wen_q;
    if (issue) begin
      wen_d = 1'b1;
      unique case (state_d)
        WR_CHAR: begin
          addr_d  = BASE + {20'b0, idx};
          wdata_d = {4{char_d}};
          wmask_d = 4'b0001 << idx[1:0];
        end
        WR_COLOR: begin
          addr_d  = COL_BASE + {18'b0, idx, 2'b00};
          wdata_d = {20'b0, lat_d};
          wmask_d = 4'b0011;
        end
        LINE_CHR: begin
          addr_d  = BASE + {20'b0, lbase} + {18'b0, cnt_d, 2'b00};
          wdata_d = SPACES;
          wmask_d = 4'b1111;
        end
        LINE_COL: begin
          addr_d  = COL_BASE + {18'b0, lcell, 2'b00};
          wdata_d = {20'b0, lat_d};
          wmask_d = 4'b0011;
        end
        CLR_CHR: begin
          addr_d  = BASE + {18'b0, cnt_d, 2'b00};
          wdata_d = SPACES;
          wmask_d = 4'b1111;
        end
        CLR_COL: begin
          addr_d  = COL_BASE + {18'b0, cnt_d, 2'b00};
          wdata_d = {20'b0, lat_d};
          wmask_d = 4'b0011;
        end
        default: wen_d = 1'b0;
      endcase
    end else if (done) begin
      wen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      clr_row_q <= '0;
      attr_q    <= DEFAULT_COLOR;
      lat_q     <= DEFAULT_COLOR;
      char_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      wen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      clr_row_q <= clr_row_d;
      attr_q    <= attr_d;
      lat_q     <= lat_d;
      char_q    <= char_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      wen_q     <= wen_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign wmask      = wmask_q;
  assign wen        = wen_q;
  assign ren        = 1'b0;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: bus writes are captured
// into queues and compared against hand-computed addresses and data.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] color_in;
  logic        color_we;
  logic        clear;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ren;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qd[$];
  logic [3:0]  qm[$];

  text_console_writer dut (
    .clk(clk), .rst(rst),
    .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .color_in(color_in), .color_we(color_we), .clear(clear),
    .busy(busy), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
    .ready(ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && wen && ready) begin
      qa.push_back(addr);
      qd.push_back(wdata);
      qm.push_back(wmask);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic qclr();
    qa.delete();
    qd.delete();
    qm.delete();
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("send_timeout", 32'(n), 32'd0);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    chk({tag, "_addr"}, qa[i], a);
    chk({tag, "_data"}, qd[i], d);
    chk({tag, "_mask"}, 32'(qm[i]), 32'(m));
  endtask

  initial begin
    int n;
    int bad;
    rst        = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    color_in   = 12'h000;
    color_we   = 1'b0;
    clear      = 1'b0;
    ready      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wmask", 32'(wmask), 32'd0);
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(char_ready), 32'd1);
    chk("post_rst_nowr", 32'(qa.size()), 32'd0);

    // single printable
    send(8'h41);
    wait_idle();
    chk("A_count", 32'(qa.size()), 32'd2);
    chk_wr("A_chr", 0, 32'h10000, 32'h41414141, 4'b0001);
    chk_wr("A_col", 1, 32'h10960, 32'h0000003F, 4'b0011);
    chk("A_col", 32'(cursor_col), 32'd1);
    chk("A_row", 32'(cursor_row), 32'd0);
    chk("A_ready", 32'(char_ready), 32'd1);

    // carriage return
    qclr();
    send(8'h0D);
    chk("cr_nowr", 32'(qa.size()), 32'd0);
    chk("cr_col", 32'(cursor_col), 32'd0);
    chk("cr_row", 32'(cursor_row), 32'd0);

    // full row of printables, wrap clears row 1
    for (int i = 0; i < 80; i++) send(8'h78);
    wait_idle();
    chk("row_count", 32'(qa.size()), 32'd260);
    chk_wr("row_last_chr", 158, 32'h1004F, 32'h78787878, 4'b1000);
    chk_wr("row_last_col", 159, 32'h10A9C, 32'h0000003F, 4'b0011);
    chk_wr("row_lc_first", 160, 32'h10050, 32'h20202020, 4'b1111);
    chk_wr("row_lc_last", 179, 32'h1009C, 32'h20202020, 4'b1111);
    chk_wr("row_lk_first", 180, 32'h10AA0, 32'h0000003F, 4'b0011);
    chk_wr("row_lk_last", 259, 32'h10BDC, 32'h0000003F, 4'b0011);
    chk("row_col", 32'(cursor_col), 32'd0);
    chk("row_row", 32'(cursor_row), 32'd1);

    // move to (29,5), newline wraps to row 0
    for (int i = 0; i < 28; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    wait_idle();
    chk("pre_wrap_row", 32'(cursor_row), 32'd29);
    chk("pre_wrap_col", 32'(cursor_col), 32'd5);
    qclr();
    send(8'h0A);
    wait_idle();
    chk("lf_count", 32'(qa.size()), 32'd100);
    chk_wr("lf_c_first", 0, 32'h10000, 32'h20202020, 4'b1111);
    chk_wr("lf_c_last", 19, 32'h1004C, 32'h20202020, 4'b1111);
    chk_wr("lf_k_first", 20, 32'h10960, 32'h0000003F, 4'b0011);
    chk_wr("lf_k_last", 99, 32'h10A9C, 32'h0000003F, 4'b0011);
    chk("lf_row", 32'(cursor_row), 32'd0);
    chk("lf_col", 32'(cursor_col), 32'd0);
    qclr();
    send(8'h0D);
    send(8'h08);
    repeat (2) @(negedge clk);
    chk("cr_bs_nowr", 32'(qa.size()), 32'd0);
    chk("cr_bs_col", 32'(cursor_col), 32'd0);
    chk("cr_bs_row", 32'(cursor_row), 32'd0);

    // backspace from a nonzero column
    send(8'h78);
    send(8'h78);
    wait_idle();
    send(8'h08);
    chk("bs_col", 32'(cursor_col), 32'd1);

    // clear beats a pending codepoint
    @(negedge clk);
    color_in = 12'hFC0;
    color_we = 1'b1;
    @(negedge clk);
    color_we = 1'b0;
    qclr();
    clear      = 1'b1;
    char_in    = 8'h42;
    char_valid = 1'b1;
    #1;
    chk("clr_prio_ready", 32'(char_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    bad = 0;
    n = 0;
    while (qa.size() < 3000 && n < 4000) begin
      if (!busy || char_ready) bad++;
      @(negedge clk);
      n++;
    end
    chk("clr_busy_held", 32'(bad), 32'd0);
    chk("clr_count", 32'(qa.size()), 32'd3000);
    chk_wr("clr_c_first", 0, 32'h10000, 32'h20202020, 4'b1111);
    chk_wr("clr_c_last", 599, 32'h1095C, 32'h20202020, 4'b1111);
    chk_wr("clr_k_first", 600, 32'h10960, 32'h00000FC0, 4'b0011);
    chk_wr("clr_k_last", 2999, 32'h12EDC, 32'h00000FC0, 4'b0011);
    chk("clr_col", 32'(cursor_col), 32'd0);
    chk("clr_row", 32'(cursor_row), 32'd0);
    chk("clr_idle", 32'(busy), 32'd0);
    @(negedge clk);
    char_valid = 1'b0;
    wait_idle();
    chk("held_count", 32'(qa.size()), 32'd3002);
    chk_wr("held_chr", 3000, 32'h10000, 32'h42424242, 4'b0001);
    chk_wr("held_col", 3001, 32'h10960, 32'h00000FC0, 4'b0011);

    // backpressure on a char write
    qclr();
    @(negedge clk);
    ready = 1'b0;
    send(8'h43);
    for (int i = 0; i < 5; i++) begin
      chk("bp_wen", 32'(wen), 32'd1);
      chk("bp_addr", addr, 32'h10001);
      chk("bp_wdata", wdata, 32'h43434343);
      chk("bp_wmask", 32'(wmask), 32'b0010);
      chk("bp_nowr", 32'(qa.size()), 32'd0);
      @(negedge clk);
    end
    ready = 1'b1;
    wait_idle();
    chk("bp_count", 32'(qa.size()), 32'd2);
    chk_wr("bp_chr", 0, 32'h10001, 32'h43434343, 4'b0010);
    chk_wr("bp_col", 1, 32'h10964, 32'h00000FC0, 4'b0011);
    chk("bp_cur", 32'(cursor_col), 32'd2);

    // reset in the middle of the colour clear
    qclr();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    while (qa.size() < 700 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", 32'(qa.size() >= 700), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(wen), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    qclr();
    repeat (5) @(negedge clk);
    chk("post_mid_nowr", 32'(qa.size()), 32'd0);
    chk("post_mid_busy", 32'(busy), 32'd0);
    chk("post_mid_col", 32'(cursor_col), 32'd0);
    send(8'h44);
    wait_idle();
    chk("post_mid_count", 32'(qa.size()), 32'd2);
    chk_wr("post_mid_chr", 0, 32'h10000, 32'h44444444, 4'b0001);
    chk_wr("post_mid_attr", 1, 32'h10960, 32'h0000003F, 4'b0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
